// File: rtl/snes_ctrl_pkg.sv
// Shared constants and types for the SNES controller-port transmitter.
// Button indices follow the order the console shifts them in.
`timescale 1ns/1ps
package snes_ctrl_pkg;

  localparam int NBITS = 16;
  localparam int IDX_W = 5;

  localparam int BTN_B     = 0;
  localparam int BTN_Y     = 1;
  localparam int BTN_SEL   = 2;
  localparam int BTN_START = 3;
  localparam int BTN_UP    = 4;
  localparam int BTN_DOWN  = 5;
  localparam int BTN_LEFT  = 6;
  localparam int BTN_RIGHT = 7;
  localparam int BTN_A     = 8;
  localparam int BTN_X     = 9;
  localparam int BTN_L     = 10;
  localparam int BTN_R     = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/snes_pin_filter.sv
// Synchronizer plus stability filter for one async console pin.
// level only follows the synced pin after GLITCH_CYC stable cycles; edge_stb pulses on that change.
`timescale 1ns/1ps
module snes_pin_filter #(
  parameter int   SYNC_STAGES = 2,
  parameter int   GLITCH_CYC  = 4,
  parameter logic IDLE_LVL    = 1'b0
) (
  input  logic mclock,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic edge_stb
);

  localparam int CW = $clog2(GLITCH_CYC + 1);
  localparam logic [CW-1:0] TC_LOAD = CW'(GLITCH_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          stab_cnt_q;
  logic                   sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Down-counter runs only while the synced level disagrees with the accepted one;
  // reaching terminal count with the disagreement still present accepts the edge.
  always_ff @(posedge mclock or posedge rst) begin
    if (rst) begin
      sync_q     <= {SYNC_STAGES{IDLE_LVL}};
      stab_cnt_q <= TC_LOAD;
      level      <= IDLE_LVL;
      edge_stb   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pin};
      edge_stb <= 1'b0;
      if (sync_lvl == level) begin
        stab_cnt_q <= TC_LOAD;
      end else if (stab_cnt_q == '0) begin
        level      <= sync_lvl;
        edge_stb   <= 1'b1;
        stab_cnt_q <= TC_LOAD;
      end else begin
        stab_cnt_q <= stab_cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/snes_ctrl_tx.sv
// Controller-port responder: shifts the real pad (masked) or an injected button word
// back to the console, paced by the console's latch and serial clock pins.
//
//   state | meaning
//   IDLE  | no frame since reset; pass-through mirrors the raw pad
//   LATCH | latch high; word and mask track their inputs live
//   SHIFT | latch released; each accepted clock rise advances bit_idx
//   DONE  | all NBITS bits shifted; waits for the next latch rise
`timescale 1ns/1ps
module snes_ctrl_tx
  import snes_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_CYC  = 4
) (
  input  logic             CLK_i,
  input  logic             RST_i,
  input  logic             CTRL_LATCH_i,
  input  logic             CTRL_CLK_i,
  input  logic             CTRL_SDATA_i,
  input  logic             inject_en_i,
  input  logic [NBITS-1:0] inject_data_i,
  input  logic [NBITS-1:0] mask_i,
  output logic             CTRL_SDATA_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic [4:0]       bit_idx_o
);

  localparam int SEL_W = $clog2(NBITS);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NBITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBITS - 1);

  logic latch_lvl, latch_edge, clk_lvl, clk_edge;
  logic latch_rise, latch_fall, clk_rise;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               mode_q, mode_d;
  logic [NBITS-1:0]   word_q, word_d;
  logic [NBITS-1:0]   mask_q, mask_d;
  logic               sdata_q, sdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SEL_W-1:0]   sel;
  logic               in_range;

  snes_pin_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .GLITCH_CYC  (GLITCH_CYC),
    .IDLE_LVL    (1'b0)
  ) u_latch_filt (
    .mclock   (CLK_i),
    .rst      (RST_i),
    .pin      (CTRL_LATCH_i),
    .level    (latch_lvl),
    .edge_stb (latch_edge)
  );

  // Console clock idles high between frames.
  snes_pin_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .GLITCH_CYC  (GLITCH_CYC),
    .IDLE_LVL    (1'b1)
  ) u_clk_filt (
    .mclock   (CLK_i),
    .rst      (RST_i),
    .pin      (CTRL_CLK_i),
    .level    (clk_lvl),
    .edge_stb (clk_edge)
  );

  assign latch_rise = latch_edge & latch_lvl;
  assign latch_fall = latch_edge & ~latch_lvl;
  assign clk_rise   = clk_edge & clk_lvl;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    word_d  = word_q;
    mask_d  = mask_q;
    done_d  = 1'b0;

    // A latch rise restarts the frame from any state and swallows a coincident clock rise.
    if (latch_rise) begin
      state_d = LATCH;
      idx_d   = '0;
      mode_d  = inject_en_i;
      word_d  = inject_data_i;
      mask_d  = mask_i;
    end else begin
      case (state_q)
        LATCH: begin
          word_d = inject_data_i;
          mask_d = mask_i;
          if (latch_fall) state_d = SHIFT;
        end
        SHIFT: begin
          if (clk_rise) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    in_range = (idx_d < IDX_END);
    sel      = idx_d[SEL_W-1:0];

    // Past the last button the wire reads logical 1 (low) when injecting.
    if (state_d == IDLE) begin
      sdata_d = mode_d ? 1'b1 : CTRL_SDATA_i;
    end else if (mode_d) begin
      sdata_d = in_range ? ~word_d[sel] : 1'b0;
    end else begin
      sdata_d = in_range ? (CTRL_SDATA_i | mask_d[sel]) : CTRL_SDATA_i;
    end

    busy_d = (state_d == LATCH) || (state_d == SHIFT);
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      word_q  <= '0;
      mask_q  <= '0;
      sdata_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      sdata_q <= sdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign CTRL_SDATA_o = sdata_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign bit_idx_o    = idx_q;

endmodule
